// File: rtl/xgemac_wb_pkg.sv
// rtl/xgemac_wb_pkg.sv - shared types and defaults for the XGEMAC wishbone request master
package xgemac_wb_pkg;

  localparam int DEF_ADDR_WIDTH     = 8;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_MAX_BURST      = 4;
  localparam int DEF_ADDR_STRIDE    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  // A single-beat configuration still needs a 1-bit length field.
  function automatic int len_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

  localparam int DEF_LEN_WIDTH = len_width(DEF_MAX_BURST);

  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
    logic [DEF_LEN_WIDTH-1:0]  len;
  } req_t;

endpackage

// File: rtl/xgemac_wb_int_latch.sv
// rtl/xgemac_wb_int_latch.sv - rising-edge detect of the slave interrupt into a sticky pending flag
module xgemac_wb_int_latch (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic clr,
  output logic pending
);

  logic irq_prev_q, irq_prev_d;
  logic pending_q, pending_d;

  // A new edge beats a coincident clear so no interrupt is ever lost.
  always_comb begin
    irq_prev_d = irq;
    pending_d  = pending_q;
    if (clr)
      pending_d = 1'b0;
    if (irq && !irq_prev_q)
      pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/xgemac_wb_req_master.sv
// rtl/xgemac_wb_req_master.sv - wishbone classic master turning single/burst requests into per-beat bus cycles
module xgemac_wb_req_master
  import xgemac_wb_pkg::*;
#(
  parameter  int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter  int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter  int MAX_BURST      = DEF_MAX_BURST,
  parameter  int ADDR_STRIDE    = DEF_ADDR_STRIDE,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int LEN_WIDTH      = len_width(MAX_BURST)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_last,
  output logic [ADDR_WIDTH-1:0] wb_adr_i,
  output logic                  wb_cyc_i,
  output logic                  wb_stb_i,
  output logic                  wb_we_i,
  output logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic                  wb_int_o,
  input  logic                  int_clr,
  output logic                  int_pending
);

  localparam int TCNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [TCNT_WIDTH-1:0] TCNT_LAST = TCNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [TCNT_WIDTH-1:0] tcnt_q, tcnt_d;

  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_last_q, rsp_last_d;
  logic                  wb_cyc_q, wb_cyc_d;
  logic                  wb_we_q, wb_we_d;
  logic [ADDR_WIDTH-1:0] wb_adr_q, wb_adr_d;
  logic [DATA_WIDTH-1:0] wb_dat_q, wb_dat_d;
  logic                  bus_next;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    len_d       = len_q;
    beat_d      = beat_q;
    tcnt_d      = tcnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_last_d  = rsp_last_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          len_d   = (MAX_BURST > 1) ? req_len : '0;
          beat_d  = '0;
          tcnt_d  = '0;
          state_d = BUS;
        end
      end

      BUS: begin
        // An ack on the last allowed cycle is still a good beat.
        if (wb_ack_o) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : wb_dat_o;
          rsp_err_d   = 1'b0;
          rsp_last_d  = (beat_q == len_q);
          state_d     = RESP;
        end else if (tcnt_q == TCNT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_last_d  = 1'b1;
          state_d     = RESP;
        end else begin
          tcnt_d = tcnt_q + TCNT_WIDTH'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          rsp_last_d  = 1'b0;
          if (rsp_last_q) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(ADDR_STRIDE);
            beat_d  = beat_q + LEN_WIDTH'(1);
            tcnt_d  = '0;
            state_d = BUS;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Bus and handshake outputs are registered from the next state so they hold for the whole beat.
    bus_next    = (state_d == BUS);
    wb_cyc_d    = bus_next;
    wb_we_d     = bus_next && we_d;
    wb_adr_d    = bus_next ? addr_d : '0;
    wb_dat_d    = (bus_next && we_d) ? wdata_d : '0;
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      tcnt_q      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
      wb_cyc_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_adr_q    <= '0;
      wb_dat_q    <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      tcnt_q      <= tcnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_last_q  <= rsp_last_d;
      wb_cyc_q    <= wb_cyc_d;
      wb_we_q     <= wb_we_d;
      wb_adr_q    <= wb_adr_d;
      wb_dat_q    <= wb_dat_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_last  = rsp_last_q;
  assign wb_cyc_i  = wb_cyc_q;
  assign wb_stb_i  = wb_cyc_q;
  assign wb_we_i   = wb_we_q;
  assign wb_adr_i  = wb_adr_q;
  assign wb_dat_i  = wb_dat_q;

  xgemac_wb_int_latch u_int_latch (
    .clk     (clk),
    .rst     (rst),
    .irq     (wb_int_o),
    .clr     (int_clr),
    .pending (int_pending)
  );

endmodule

// File: tb/tb_xgemac_wb_req_master.sv
// tb/tb_xgemac_wb_req_master.sv - scoreboard bench for the wishbone request master
module tb_xgemac_wb_req_master;
  import xgemac_wb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int LW = 2;
  localparam int STRIDE = 4;
  localparam int TO = 16;

  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] dat;
    int            cycles;
  } beat_exp_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          last;
  } rsp_exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [LW-1:0] req_len;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_last;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] wb_adr_i;
  logic          wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o, wb_int_o, int_clr, int_pending;
  logic [DW-1:0] wb_dat_i, wb_dat_o;

  beat_exp_t     beat_q[$];
  rsp_exp_t      rsp_q[$];
  int            delay_q[$];
  logic [DW-1:0] mem[256];
  int            checks = 0;
  int            passes = 0;
  bit            ignore_bus = 1'b0;
  bit            bp_rand = 1'b0;
  int            hold_cnt = 0;

  xgemac_wb_req_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_last(rsp_last),
    .wb_adr_i(wb_adr_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_dat_i(wb_dat_i), .wb_ack_o(wb_ack_o),
    .wb_dat_o(wb_dat_o), .wb_int_o(wb_int_o), .int_clr(int_clr),
    .int_pending(int_pending)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Slave model and bus-side scoreboard: acks after a per-beat delay, checks address/data/duration.
  initial begin : slave
    bit        in_beat, have;
    int        cnt, cur_delay;
    beat_exp_t cur;
    in_beat = 0; have = 0; cnt = 0; cur_delay = 0;
    wb_ack_o = 1'b0; wb_dat_o = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_beat = 0; have = 0; wb_ack_o = 1'b0;
      end else if (wb_stb_i) begin
        if (!in_beat) begin
          in_beat = 1; cnt = 0;
          if (delay_q.size() != 0) cur_delay = delay_q.pop_front();
          else cur_delay = 1000;
          if (!ignore_bus) begin
            checks++;
            if (beat_q.size() == 0) begin
              $display("FAIL unexpected_beat: stb at adr 0x%0h, required no beat", wb_adr_i);
            end else begin
              passes++;
              cur = beat_q.pop_front();
              have = 1;
            end
          end
        end else begin
          cnt++;
        end
        if (have) begin
          chk("wb_adr", 64'(wb_adr_i), 64'(cur.adr));
          chk("wb_we", 64'(wb_we_i), 64'(cur.we));
          chk("wb_dat", 64'(wb_dat_i), 64'(cur.dat));
          chk("wb_cyc", 64'(wb_cyc_i), 64'(1));
        end
        wb_ack_o = (cnt == cur_delay);
        wb_dat_o = wb_ack_o ? mem[wb_adr_i] : $urandom;
      end else begin
        if (have) chk("stb_cycles", 64'(cnt + 1), 64'(cur.cycles));
        in_beat = 0; have = 0;
        wb_ack_o = ($urandom_range(0, 3) == 0);
        wb_dat_o = $urandom;
      end
    end
  end

  // Response monitor: drives rsp_ready, checks holding under backpressure and pops expectations.
  initial begin : rsp_mon
    bit            stalled;
    logic [DW-1:0] h_rdata;
    logic          h_err, h_last;
    rsp_exp_t      e;
    stalled = 0; h_rdata = '0; h_err = 0; h_last = 0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0; rsp_ready = 1'b0;
      end else if (rsp_valid) begin
        if (stalled) begin
          chk("rsp_hold_rdata", 64'(rsp_rdata), 64'(h_rdata));
          chk("rsp_hold_err", 64'(rsp_err), 64'(h_err));
          chk("rsp_hold_last", 64'(rsp_last), 64'(h_last));
        end
        chk("no_cyc_in_resp", 64'(wb_cyc_i), 64'(0));
        if (hold_cnt > 0) begin
          rsp_ready = 1'b0;
          hold_cnt--;
        end else begin
          rsp_ready = bp_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (rsp_ready) begin
          stalled = 0;
          checks++;
          if (rsp_q.size() == 0) begin
            $display("FAIL unexpected_rsp: rdata 0x%0h err %0b, required no response", rsp_rdata, rsp_err);
          end else begin
            passes++;
            e = rsp_q.pop_front();
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            chk("rsp_last", 64'(rsp_last), 64'(e.last));
          end
        end else begin
          stalled = 1;
          h_rdata = rsp_rdata; h_err = rsp_err; h_last = rsp_last;
        end
      end else begin
        checks++;
        if (stalled) $display("FAIL rsp_dropped: rsp_valid 0 while stalled, required 1");
        else passes++;
        stalled = 0;
        rsp_ready = ($urandom_range(0, 1) == 1);
      end
    end
  end

  task automatic issue(input req_t r);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = r.we; req_addr = r.addr; req_wdata = r.wdata; req_len = r.len;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept_in_time", 64'(n < 200), 64'(1));
    @(negedge clk);
    req_valid = 1'b0;
    chk("req_to_stb_latency", 64'(wb_stb_i), 64'(1));
  endtask

  // Reference model: beat addresses step by the stride mod 256; a delay of TO or more is a timeout
  // that ends the request with an error and drops the remaining beats.
  task automatic do_req(input req_t r, input int dl[4]);
    logic [AW-1:0] a;
    bit            to;
    int            n;
    beat_exp_t     b;
    rsp_exp_t      e;
    for (int i = 0; i <= int'(r.len); i++) begin
      a = AW'((int'(r.addr) + i * STRIDE) % 256);
      to = (dl[i] >= TO);
      b.adr = a; b.we = r.we; b.dat = r.we ? r.wdata : 32'h0; b.cycles = to ? TO : dl[i] + 1;
      e.rdata = (to || r.we) ? 32'h0 : mem[a]; e.err = to; e.last = (i == int'(r.len)) || to;
      beat_q.push_back(b);
      rsp_q.push_back(e);
      delay_q.push_back(dl[i]);
      if (to) break;
    end
    issue(r);
    n = 0;
    while ((rsp_q.size() != 0 || beat_q.size() != 0 || !req_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("request_completes", 64'(n < 1000), 64'(1));
  endtask

  function automatic int rand_delay();
    int k;
    k = $urandom_range(0, 11);
    if (k < 10) return $urandom_range(0, 4);
    if (k == 10) return TO - 1;
    return $urandom_range(TO, TO + 4);
  endfunction

  initial begin : main
    req_t r;
    int   dl[4];
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_len = '0;
    wb_int_o = 1'b0; int_clr = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'h11; mem[8'h14] = 32'h22; mem[8'h18] = 32'h33; mem[8'h1C] = 32'h44;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_cyc", 64'(wb_cyc_i), 64'(0));
    chk("rst_stb", 64'(wb_stb_i), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_int_pending", 64'(int_pending), 64'(0));
    chk("rst_adr", 64'(wb_adr_i), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rst", 64'(req_ready), 64'(1));

    // Single write, ack two cycles after strobe.
    r = '{we: 1'b1, addr: 8'h08, wdata: 32'hDEADBEEF, len: 2'd0};
    dl = '{2, 0, 0, 0};
    do_req(r, dl);

    // Read burst with combinational acks.
    r = '{we: 1'b0, addr: 8'h10, wdata: 32'h0, len: 2'd3};
    dl = '{0, 0, 0, 0};
    do_req(r, dl);

    // Timeout on the first beat drops the rest.
    r = '{we: 1'b0, addr: 8'h40, wdata: 32'h0, len: 2'd2};
    dl = '{40, 0, 0, 0};
    do_req(r, dl);

    // Ack on the final allowed cycle is a normal response.
    r = '{we: 1'b1, addr: 8'h80, wdata: 32'hA5A55A5A, len: 2'd1};
    dl = '{TO - 1, 1, 0, 0};
    do_req(r, dl);

    // Backpressure on the first response and address wrap.
    hold_cnt = 5;
    r = '{we: 1'b0, addr: 8'hFC, wdata: 32'h0, len: 2'd1};
    dl = '{1, 0, 0, 0};
    do_req(r, dl);

    // Randomized requests with random backpressure.
    bp_rand = 1'b1;
    for (int t = 0; t < 30; t++) begin
      r.we = 1'($urandom_range(0, 1));
      r.addr = AW'($urandom_range(0, 255));
      r.wdata = $urandom;
      r.len = LW'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) dl[i] = rand_delay();
      do_req(r, dl);
    end
    bp_rand = 1'b0;

    // Interrupt edge, coincident clear, clear alone, level held high.
    @(negedge clk); wb_int_o = 1'b1;
    @(negedge clk); wb_int_o = 1'b0;
    chk("int_set_on_rise", 64'(int_pending), 64'(1));
    @(negedge clk);
    chk("int_sticky", 64'(int_pending), 64'(1));
    wb_int_o = 1'b1; int_clr = 1'b1;
    @(negedge clk);
    chk("int_rise_beats_clr", 64'(int_pending), 64'(1));
    int_clr = 1'b1;
    @(negedge clk);
    chk("int_clr_alone", 64'(int_pending), 64'(0));
    int_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("int_level_no_reset", 64'(int_pending), 64'(0));
    end
    wb_int_o = 1'b0;

    // Reset in the middle of a beat that never acks.
    @(negedge clk); wb_int_o = 1'b1;
    @(negedge clk); wb_int_o = 1'b0;
    chk("int_set_before_rst", 64'(int_pending), 64'(1));
    ignore_bus = 1'b1;
    delay_q.push_back(1000);
    r = '{we: 1'b1, addr: 8'h20, wdata: 32'h12345678, len: 2'd3};
    issue(r);
    repeat (2) @(negedge clk);
    chk("stb_before_rst", 64'(wb_stb_i), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cyc", 64'(wb_cyc_i), 64'(0));
    chk("midrst_stb", 64'(wb_stb_i), 64'(0));
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("midrst_req_ready", 64'(req_ready), 64'(0));
    chk("midrst_int_pending", 64'(int_pending), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready_after", 64'(req_ready), 64'(1));
    delay_q.delete(); beat_q.delete(); rsp_q.delete();
    ignore_bus = 1'b0;

    r = '{we: 1'b0, addr: 8'h1C, wdata: 32'h0, len: 2'd0};
    dl = '{3, 0, 0, 0};
    do_req(r, dl);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
